// File: rtl/fpu_share_arbiter.sv
// Shares one FPUnit between NUM_REQ requesters with round-robin selection; one request in flight.
// Latency: accept edge -> start next cycle -> result pulse one cycle after fpu_done (or watchdog abort).
// Backpressure: req_ready pulses only in IDLE; requesters hold req_valid until their accept pulse.
module fpu_share_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int OP_W        = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [DATA_W-1:0]         resp_data,
    output logic [OP_W-1:0]           fpu_op,
    output logic [DATA_W-1:0]         fpu_a,
    output logic [DATA_W-1:0]         fpu_b,
    output logic                      fpu_start,
    input  logic                      fpu_done,
    input  logic [DATA_W-1:0]         fpu_result,
    output logic                      busy,
    output logic                      err_timeout
);

    localparam int GW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WDW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [WDW-1:0]    WD_LAST = WDW'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);
    localparam logic [DATA_W-1:0] QNAN    = DATA_W'(32'h7FC0_0000);

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     gnt_q, gnt_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [WDW-1:0]    wd_q, wd_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              err_q, err_d;

    logic              hit;
    logic [GW-1:0]     sel;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!hit && req_valid[(int'(rr_ptr_q) + i) % NUM_REQ]) begin
                hit = 1'b1;
                sel = GW'((int'(rr_ptr_q) + i) % NUM_REQ);
            end
        end
    end

    // Sequencer next state; operands latched only at the accept edge.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        gnt_d       = gnt_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        wd_d        = wd_q;
        resp_data_d = resp_data_q;
        err_d       = err_q;
        req_ready   = '0;
        resp_valid  = '0;
        case (state_q)
            S_IDLE: begin
                if (hit) begin
                    req_ready[sel] = 1'b1;
                    op_d           = req_op[sel*OP_W +: OP_W];
                    a_d            = req_a[sel*DATA_W +: DATA_W];
                    b_d            = req_b[sel*DATA_W +: DATA_W];
                    gnt_d          = sel;
                    state_d        = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // fpu_done is deliberately not looked at here.
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (fpu_done) begin
                    resp_data_d = fpu_result;
                    state_d     = S_RESP;
                end else begin
                    // Saturate so a disabled watchdog never wraps.
                    wd_d = (wd_q == '1) ? wd_q : wd_q + WDW'(1);
                    if (TIMEOUT_CYC != 0 && wd_q == WD_LAST) begin
                        resp_data_d = QNAN;
                        err_d       = 1'b1;
                        state_d     = S_RESP;
                    end
                end
            end
            default: begin
                resp_valid[gnt_q] = 1'b1;
                // Last served requester drops to lowest priority.
                rr_ptr_d = (gnt_q == GW'(NUM_REQ - 1)) ? '0 : gnt_q + GW'(1);
                state_d  = S_IDLE;
            end
        endcase
    end

    // State registers; reset aborts any in-flight request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_ptr_q    <= '0;
            gnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            wd_q        <= '0;
            resp_data_q <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            gnt_q       <= gnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            wd_q        <= wd_d;
            resp_data_q <= resp_data_d;
            err_q       <= err_d;
        end
    end

    assign fpu_start   = (state_q == S_ISSUE);
    assign fpu_op      = op_q;
    assign fpu_a       = a_q;
    assign fpu_b       = b_q;
    assign busy        = (state_q != S_IDLE);
    assign resp_data   = resp_data_q;
    assign err_timeout = err_q;

endmodule
